// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store master.
// LSU_SUBWORD_STORE_EN adds the read-modify-write states used by SB/SH.
package lsu_pkg;

  // RV32I funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LD_RSP,
    WR,
    RSP
`ifdef LSU_SUBWORD_STORE_EN
    , RMW_RD,
    RMW_WR
`endif
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  // The low two funct3 bits carry the access width for every legal encoding
  function automatic lsu_size_t access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return SZ_B;
      2'd1:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: request/response handshake plus word-memory bus.
// master = the load/store unit, slave = the core/memory side.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte/halfword lane handling between the core and a word memory.
// Load path always present; store merge exists only with LSU_SUBWORD_STORE_EN.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o
`ifdef LSU_SUBWORD_STORE_EN
  ,
  input  logic [15:0] wdata_i,
  output logic [31:0] merged_o
`endif
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed lane and extend it to 32 bits
  always_comb begin
    byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data_o = {24'd0, byte_lane};
      F3_H:    load_data_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data_o = {16'd0, half_lane};
      default: load_data_o = rdata_i;
    endcase
  end

`ifdef LSU_SUBWORD_STORE_EN
  // Overlay the new byte/half on the old word, keeping every other lane
  always_comb begin
    merged_o = rdata_i;
    if (access_size(funct3_i) == SZ_B) begin
      merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
    end else begin
      merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i;
    end
  end
`endif

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding RV32I load/store initiator for a
// word-organised data memory with one-cycle read latency.
// LSU_SUBWORD_STORE_EN: SB/SH via read-modify-write; undefined, they are rejected.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_mem_master_if.master bus
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_r_enable_q, mem_r_enable_d;
  logic        mem_w_enable_q, mem_w_enable_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        accept, acc_err, f3_illegal, misaligned, out_of_range;
  logic [31:0] load_data;
`ifdef LSU_SUBWORD_STORE_EN
  logic [31:0] merged_word;
`endif

  lsu_align u_align (
    .funct3_i    (funct3_q),
    .addr_lo_i   (addr_q[1:0]),
    .rdata_i     (bus.mem_rdata),
    .load_data_o (load_data)
`ifdef LSU_SUBWORD_STORE_EN
    ,
    .wdata_i     (wdata_q[15:0]),
    .merged_o    (merged_word)
`endif
  );

  // Classify the incoming request as legal or as an error response
  always_comb begin
    if (bus.req_we) begin
`ifdef LSU_SUBWORD_STORE_EN
      f3_illegal = (bus.req_funct3 > F3_W);
`else
      f3_illegal = (bus.req_funct3 != F3_W);
`endif
    end else begin
      f3_illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 > F3_HU);
    end
    case (access_size(bus.req_funct3))
      SZ_H:    misaligned = bus.req_addr[0];
      SZ_W:    misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = {2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS);
    acc_err      = f3_illegal | misaligned | out_of_range;
  end

  // Next state, request latching, and the registered outputs of the next state
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept   = 1'b1;
          addr_d   = bus.req_addr;
          funct3_d = bus.req_funct3;
          we_d     = bus.req_we;
          wdata_d  = bus.req_wdata;
          if (acc_err)                        state_d = RSP;
          else if (!bus.req_we)               state_d = RD;
`ifdef LSU_SUBWORD_STORE_EN
          else if (bus.req_funct3 == F3_W)    state_d = WR;
          else                                state_d = RMW_RD;
`else
          else                                state_d = WR;
`endif
        end
      end
      RD:      state_d = LD_RSP;
      LD_RSP:  state_d = IDLE;
      WR:      state_d = RSP;
      RSP:     state_d = IDLE;
`ifdef LSU_SUBWORD_STORE_EN
      // First cycle strobes the read; second cycle sees the returned word
      RMW_RD:  state_d = mem_r_enable_q ? RMW_RD : RMW_WR;
      RMW_WR:  state_d = RSP;
`endif
      default: state_d = IDLE;
    endcase

    req_ready_d    = (state_d == IDLE);
    resp_valid_d   = (state_d == RSP) || (state_d == LD_RSP);
    resp_err_d     = accept && acc_err;
    mem_r_enable_d = (state_d == RD);
    mem_w_enable_d = (state_d == WR);
    mem_wdata_d    = (state_d == WR) ? wdata_d : '0;
`ifdef LSU_SUBWORD_STORE_EN
    if (state_d == RMW_RD && state_q != RMW_RD) mem_r_enable_d = 1'b1;
    if (state_d == RMW_WR) begin
      mem_w_enable_d = 1'b1;
      mem_wdata_d    = merged_word;
    end
`endif
    mem_addr_d = (mem_r_enable_d || mem_w_enable_d) ? {addr_d[31:2], 2'b00} : '0;
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      funct3_q       <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      mem_r_enable_q <= 1'b0;
      mem_w_enable_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      funct3_q       <= funct3_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      mem_r_enable_q <= mem_r_enable_d;
      mem_w_enable_q <= mem_w_enable_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_r_enable = mem_r_enable_q;
  assign bus.mem_w_enable = mem_w_enable_q;
  assign bus.mem_wdata    = mem_wdata_q;
  // Memory data arrives in the response cycle itself, so load data is
  // extracted straight from mem_rdata and gated to zero outside it.
  assign bus.resp_rdata   = (state_q == LD_RSP && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed load/store sequences against a word memory,
// checked every cycle against a transaction-level model of the LSU.
module tb_lsu_mem_master;
  localparam int MEM_WORDS = 256;
`ifdef LSU_SUBWORD_STORE_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if bus();

  lsu_mem_master #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA55A_3CC3;
  endfunction

  // ---------------- word memory attached to the DUT ----------------
  logic [31:0] tb_mem  [0:MEM_WORDS-1];
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  logic        fill = 1'b1;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] <= pattern(i);
    end else if (pre_we) begin
      tb_mem[pre_idx] <= pre_val;
    end else if (bus.mem_w_enable) begin
      tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    if (bus.mem_r_enable) bus.mem_rdata <= tb_mem[bus.mem_addr[9:2]];
  end

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic        ready, ren, wen, rv, err;
    logic [31:0] addr, wdata, rdata;
  } exp_t;

  exp_t exp_q [1:6];
  int   exp_len = 0;
  int   txn_id = 0;
  int   done_id = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  // Builds the cycle-by-cycle picture (offset 1 = cycle after acceptance)
  task automatic model_txn(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
    int unsigned sz, sh, widx;
    bit illegal, err;
    logic [31:0] w, mask, v;
    for (int k = 1; k <= 6; k++) begin
      exp_q[k].ready = 1'b0; exp_q[k].ren = 1'b0; exp_q[k].wen = 1'b0;
      exp_q[k].rv = 1'b0; exp_q[k].err = 1'b0;
      exp_q[k].addr = '0; exp_q[k].wdata = '0; exp_q[k].rdata = '0;
    end
    if (!we) illegal = (f3 == 3) || (f3 == 6) || (f3 == 7);
    else     illegal = (f3 >= 3) || (!SUB_EN && f3 != 2);
    sz   = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    widx = addr / 4;
    err  = illegal || (addr % sz != 0) || (widx >= MEM_WORDS);
    sh   = (sz == 1) ? (addr % 4) * 8 : (sz == 2) ? ((addr / 2) % 2) * 16 : 0;
    mask = (sz == 1) ? 32'hFF << sh : (sz == 2) ? 32'hFFFF << sh : 32'hFFFF_FFFF;
    if (err) begin
      exp_q[1].rv = 1'b1; exp_q[1].err = 1'b1;
      exp_len = 2;
    end else if (!we) begin
      w = ref_mem[widx];
      v = (w & mask) >> sh;
      if (f3 < 4 && sz < 4 && v[8*sz-1]) v = v | ~(mask >> sh);
      exp_q[1].ren = 1'b1; exp_q[1].addr = widx * 4;
      exp_q[2].rv = 1'b1; exp_q[2].rdata = v;
      exp_len = 3;
    end else if (sz == 4) begin
      exp_q[1].wen = 1'b1; exp_q[1].addr = widx * 4; exp_q[1].wdata = wd;
      ref_mem[widx] = wd;
      exp_q[2].rv = 1'b1;
      exp_len = 3;
    end else begin
      w = ref_mem[widx];
      v = (w & ~mask) | ((wd << sh) & mask);
      exp_q[1].ren = 1'b1; exp_q[1].addr = widx * 4;
      exp_q[3].wen = 1'b1; exp_q[3].addr = widx * 4; exp_q[3].wdata = v;
      ref_mem[widx] = v;
      exp_q[4].rv = 1'b1;
      exp_len = 5;
    end
    exp_q[exp_len].ready = 1'b1;
  endtask

  // ---------------- per-cycle compare ----------------
  int cmp_k = 0;
  int cmp_id = 0;
  always @(negedge clk) begin
    if (cmp_id != txn_id) begin
      cmp_id = txn_id;
      cmp_k  = 1;
    end
    if (cmp_k > 0) begin
      check($sformatf("req_ready t%0d+%0d", cmp_id, cmp_k), 32'(bus.req_ready), 32'(exp_q[cmp_k].ready));
      check($sformatf("mem_r_enable t%0d+%0d", cmp_id, cmp_k), 32'(bus.mem_r_enable), 32'(exp_q[cmp_k].ren));
      check($sformatf("mem_w_enable t%0d+%0d", cmp_id, cmp_k), 32'(bus.mem_w_enable), 32'(exp_q[cmp_k].wen));
      check($sformatf("resp_valid t%0d+%0d", cmp_id, cmp_k), 32'(bus.resp_valid), 32'(exp_q[cmp_k].rv));
      if (exp_q[cmp_k].ren || exp_q[cmp_k].wen)
        check($sformatf("mem_addr t%0d+%0d", cmp_id, cmp_k), bus.mem_addr, exp_q[cmp_k].addr);
      if (exp_q[cmp_k].wen)
        check($sformatf("mem_wdata t%0d+%0d", cmp_id, cmp_k), bus.mem_wdata, exp_q[cmp_k].wdata);
      if (exp_q[cmp_k].rv) begin
        check($sformatf("resp_err t%0d+%0d", cmp_id, cmp_k), 32'(bus.resp_err), 32'(exp_q[cmp_k].err));
        check($sformatf("resp_rdata t%0d+%0d", cmp_id, cmp_k), bus.resp_rdata, exp_q[cmp_k].rdata);
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
      end
      if (cmp_k >= exp_len) begin
        cmp_k   = 0;
        done_id = cmp_id;
      end else begin
        cmp_k++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_idx = 8'(idx); pre_val = val; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    int guard;
    model_txn(we, f3, addr, wd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_accept", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    txn_id++;
    guard = 0;
    while (done_id != txn_id && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("txn_complete", 32'(done_id == txn_id), 32'd1);
    $display("txn %0d we=%0b f3=%0d addr=%h wdata=%h -> err=%0b rdata=%h",
             txn_id, we, f3, addr, wd, last_err, last_rdata);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " resp_err"}, 32'(bus.resp_err), 32'd0);
    check({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
    check({tag, " mem_r_enable"}, 32'(bus.mem_r_enable), 32'd0);
    check({tag, " mem_w_enable"}, 32'(bus.mem_w_enable), 32'd0);
    check({tag, " mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int saw_w;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pattern(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in_reset");
    fill = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // sub-word loads from word 100
    poke(100, 32'hFF0F_0E0D);
    run_txn(1'b0, 3'd0, 32'd403, 32'd0);
    check("LB_403_lit", last_rdata, 32'hFFFF_FFFF);
    run_txn(1'b0, 3'd4, 32'd403, 32'd0);
    check("LBU_403_lit", last_rdata, 32'h0000_00FF);
    run_txn(1'b0, 3'd1, 32'd402, 32'd0);
    check("LH_402_lit", last_rdata, 32'hFFFF_FF0F);
    run_txn(1'b0, 3'd5, 32'd402, 32'd0);
    check("LHU_402_lit", last_rdata, 32'h0000_FF0F);
    run_txn(1'b0, 3'd0, 32'd400, 32'd0);
    check("LB_400_lit", last_rdata, 32'h0000_000D);

    // word store and read-back
    run_txn(1'b1, 3'd2, 32'd404, 32'hDEAD_BEEF);
    check("SW_404_mem_lit", tb_mem[101], 32'hDEAD_BEEF);
    run_txn(1'b0, 3'd2, 32'd404, 32'd0);
    check("LW_404_lit", last_rdata, 32'hDEAD_BEEF);

    // sub-word stores
    poke(100, 32'h0403_0201);
    run_txn(1'b1, 3'd0, 32'd401, 32'h0000_00AA);
`ifdef LSU_SUBWORD_STORE_EN
    check("SB_401_mem_lit", tb_mem[100], 32'h0403_AA01);
    run_txn(1'b1, 3'd1, 32'd402, 32'h5555_1234);
    check("SH_402_mem_lit", tb_mem[100], 32'h1234_AA01);
`else
    check("SB_401_err_lit", 32'(last_err), 32'd1);
    check("SB_401_mem_lit", tb_mem[100], 32'h0403_0201);
    run_txn(1'b1, 3'd1, 32'd402, 32'h5555_1234);
`endif
    run_txn(1'b0, 3'd2, 32'd400, 32'd0);

    // error cases: no strobe, error response one cycle after acceptance
    run_txn(1'b0, 3'd2, 32'd402, 32'd0);
    check("LW_402_err_lit", 32'(last_err), 32'd1);
    run_txn(1'b1, 3'd1, 32'd401, 32'h0000_BEEF);
    run_txn(1'b0, 3'd3, 32'd400, 32'd0);
    check("LD_f3_3_err_lit", 32'(last_err), 32'd1);
    run_txn(1'b0, 3'd6, 32'd400, 32'd0);
    run_txn(1'b0, 3'd7, 32'd400, 32'd0);
    run_txn(1'b1, 3'd3, 32'd400, 32'h1111_1111);
    run_txn(1'b0, 3'd5, 32'd403, 32'd0);

    // address range boundary
    run_txn(1'b0, 3'd2, 32'd1024, 32'd0);
    check("LW_1024_err_lit", 32'(last_err), 32'd1);
    run_txn(1'b0, 3'd2, 32'd1020, 32'd0);
    check("LW_1020_err_lit", 32'(last_err), 32'd0);
    check("LW_1020_data_lit", last_rdata, pattern(255));

    // reset in the middle of a transaction
    poke(100, 32'h0403_0201);
    @(negedge clk);
    bus.req_valid = 1'b1;
`ifdef LSU_SUBWORD_STORE_EN
    bus.req_we = 1'b1; bus.req_funct3 = 3'd0; bus.req_addr = 32'd401; bus.req_wdata = 32'hAA;
`else
    bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'd404; bus.req_wdata = 32'd0;
`endif
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("midrst_strobe_before", 32'(bus.mem_r_enable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    saw_w = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_w_enable === 1'b1) saw_w++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_write", 32'(saw_w), 32'd0);
    check_idle_outputs("post_mid_reset");
    check("midrst_mem_lit", tb_mem[100], 32'h0403_0201);
    $display("txn reset-abandoned request, memory word 100=%h", tb_mem[100]);
    run_txn(1'b0, 3'd2, 32'd404, 32'd0);
    check("LW_404_after_reset_lit", last_rdata, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the core's execute stage and the word-organised data memory.
- Accepts one RV32I load or store request at a time and drives the memory's mem_addr, mem_r_enable, mem_w_enable and mem_wdata; mem_rdata returns one cycle after a read strobe.
- Handles byte, halfword and word accesses: sub-word loads are lane-extracted and sign/zero-extended; sub-word stores use read-modify-write because the memory writes whole words only.

Parameters:
- MEM_WORDS, 256: depth of the data memory in 32-bit words. A word index addr[31:2] >= MEM_WORDS is an access error.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bits significant for SB/SH
- resp_valid  out  1  one-cycle pulse, transaction complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal funct3 or out-of-range access, valid with resp_valid
- mem_addr  out  32  word-aligned byte address to memory, bits [1:0] always 0
- mem_r_enable  out  1  read strobe
- mem_w_enable  out  1  write strobe
- mem_wdata  out  32  full write word
- mem_rdata  in  32  read data, valid the cycle after mem_r_enable

Behaviour:
- Reset: all outputs are registered and reset to 0, except req_ready, which resets to 1. State resets to IDLE.
- Reset mid-transaction: the transaction is dropped with no strobe and no response.
- States: IDLE, RD, LD_RSP, RMW_RD, RMW_WR, WR, RSP.
- IDLE: req_ready=1. On acceptance, the block latches addr, funct3, we and wdata. req_ready=0 in every other state.
- Error check at acceptance:
  - misaligned: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0;
  - illegal funct3: loads 3/6/7, stores >=3;
  - out of range: addr[31:2] >= MEM_WORDS.
- On error: go to RSP with no memory strobe. Next cycle resp_valid=1, resp_err=1, resp_rdata=0.
- Load (T = acceptance cycle):
  - T+1 in RD: mem_r_enable=1, mem_addr={addr[31:2],2'b00}.
  - T+2 in LD_RSP: resp_valid=1; resp_rdata is the lane selected by addr[1:0] (byte) or addr[1] (half), sign-extended for LB/LH and zero-extended for LBU/LHU.
  - T+3 in IDLE.
- SW: T+1 in WR (mem_w_enable=1, mem_wdata=req_wdata); T+2 in RSP (resp_valid=1); T+3 in IDLE.
- SB/SH:
  - T+1 in RMW_RD: read strobe.
  - T+2: merge the new byte or half into mem_rdata at its lane; all other bytes are preserved.
  - T+3 in RMW_WR: write strobe with the merged word.
  - T+4 in RSP: resp_valid=1.
- Invariants:
  - mem_r_enable and mem_w_enable are never high together.
  - Each strobe lasts exactly one cycle.
  - resp_valid lasts exactly one cycle.
  - No back-to-back acceptance: there is at least one IDLE cycle between transactions.
- req_valid while busy: ignored (held off by req_ready=0). The requester must hold the request until it is accepted.

Optional Feature:
- LSU_SUBWORD_STORE_EN defined: SB/SH perform the read-modify-write described above.
- Not defined: SB/SH are treated as illegal, giving RSP with resp_err=1 and no memory access. The RMW states and merge logic are absent. Loads and SW are unaffected.

Decomposition:
- lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum type lsu_state_t;
  - an access-size typedef.
- lsu_align is a combinational sub-module containing load extraction/extension and store lane merge. It is instantiated once; lsu_mem_master keeps the FSM and registers.

Test Plan:
- Memory word 100 = 32'hFF0F0E0D; LB at addr 403 -> resp_rdata=32'hFFFFFFFF at T+2; LBU 403 -> 32'h000000FF; LH 402 -> 32'hFFFFFF0F.
- SW 32'hDEADBEEF at addr 404 -> mem_w_enable one cycle at T+1 with mem_addr=404; subsequent LW 404 -> 32'hDEADBEEF.
- With LSU_SUBWORD_STORE_EN: word 100=32'h04030201, SB 32'h000000AA at addr 401 -> memory word 32'h0403AA01, resp_valid at T+4. Without the macro, the same request -> resp_err=1 at T+1, memory unchanged.
- LW at addr 402, SH at addr 401, LB with funct3=3 -> each gives resp_err=1 at T+1; mem_r_enable and mem_w_enable stay 0 throughout.
- LW at addr 1024 (MEM_WORDS=256) -> resp_err=1 with no strobe; LW at 1020 -> normal read.
- Deassert rst_n during RMW_RD of an SB -> all outputs 0 immediately, no write strobe; req_ready=1 after release; the next LW completes normally.
